// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RISC control FSM with handshaked instruction/data buses,
// a per-phase bus-wait timeout and a sticky error state.
`default_nettype none

module multicycle_ctrl #(
  parameter int RD_DIN_SEL_WIDTH = 2,
  parameter int TIMEOUT_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ibus_addr_ready,
  input  logic                        ibus_data_valid,
  input  logic                        dbus_addr_ready,
  input  logic                        dbus_data_valid,
  input  logic [5:0]                  inst_type,
  input  logic                        rd_valid,
  input  logic                        branch_taken,
  output logic                        ibus_addr_valid,
  output logic                        dbus_addr_valid,
  output logic                        dbus_write,
  output logic                        inst_fetch,
  output logic                        rs1_en,
  output logic                        rs2_en,
  output logic                        rd_en,
  output logic [RD_DIN_SEL_WIDTH-1:0] rd_din_sel,
  output logic                        pc_en,
  output logic                        pc_next_sel,
  output logic                        error,
  output logic [2:0]                  state
);

  typedef enum logic [2:0] {
    S_RESET      = 3'd0,
    S_FETCH      = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_DECODE     = 3'd3,
    S_EXEC       = 3'd4,
    S_MEM        = 3'd5,
    S_MEM_WAIT   = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] C_LAST       = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit                       C_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  if (((TIMEOUT_CYCLES >> TIMEOUT_WIDTH) != 0) || (TIMEOUT_CYCLES < 0)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be below 2**TIMEOUT_WIDTH");
  end
  if (RD_DIN_SEL_WIDTH < 2) begin : g_bad_sel_width
    $error("RD_DIN_SEL_WIDTH must be at least 2");
  end

  state_t                   state_q;
  state_t                   state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic                     waiting;
  logic                     hs;
  logic                     timeout;
  logic                     legal;

  assign legal = $onehot(inst_type);
  assign state = state_q;

  // The completing handshake of whichever bus phase we are parked in.
  always_comb begin
    waiting = 1'b0;
    hs      = 1'b0;
    case (state_q)
      S_FETCH:      begin waiting = 1'b1; hs = ibus_addr_ready; end
      S_FETCH_WAIT: begin waiting = 1'b1; hs = ibus_data_valid; end
      S_MEM:        begin waiting = 1'b1; hs = dbus_addr_ready; end
      S_MEM_WAIT:   begin waiting = 1'b1; hs = dbus_data_valid; end
      default:      begin waiting = 1'b0; hs = 1'b0; end
    endcase
  end

  assign timeout = C_TIMEOUT_EN && waiting && !hs && (cnt_q == C_LAST);

  always_comb begin
    state_d         = state_q;
    ibus_addr_valid = 1'b0;
    dbus_addr_valid = 1'b0;
    dbus_write      = 1'b0;
    inst_fetch      = 1'b0;
    rs1_en          = 1'b0;
    rs2_en          = 1'b0;
    rd_en           = 1'b0;
    rd_din_sel      = '0;
    pc_en           = 1'b0;
    pc_next_sel     = 1'b0;
    error           = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        ibus_addr_valid = 1'b1;
        if (ibus_addr_ready) state_d = S_FETCH_WAIT;
        else if (timeout)    state_d = S_ERROR;
      end
      S_FETCH_WAIT: begin
        inst_fetch = ibus_data_valid;
        if (ibus_data_valid) state_d = S_DECODE;
        else if (timeout)    state_d = S_ERROR;
      end
      S_DECODE: begin
        if (legal) begin
          rs1_en  = 1'b1;
          rs2_en  = inst_type[2] | inst_type[4] | inst_type[5];
          state_d = S_EXEC;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_EXEC: begin
        if (!legal) begin
          state_d = S_ERROR;
        end else if (inst_type[0] | inst_type[1] | inst_type[2]) begin
          rd_en      = rd_valid;
          rd_din_sel = inst_type[0] ? RD_DIN_SEL_WIDTH'(0) : RD_DIN_SEL_WIDTH'(1);
          pc_en      = 1'b1;
          state_d    = S_FETCH;
        end else if (inst_type[5]) begin
          pc_en       = 1'b1;
          pc_next_sel = branch_taken;
          state_d     = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        dbus_addr_valid = 1'b1;
        dbus_write      = inst_type[4];
        if (dbus_addr_ready) state_d = S_MEM_WAIT;
        else if (timeout)    state_d = S_ERROR;
      end
      S_MEM_WAIT: begin
        if (dbus_data_valid) begin
          if (inst_type[3]) begin
            rd_en      = rd_valid;
            rd_din_sel = RD_DIN_SEL_WIDTH'(2);
          end
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: error = 1'b1;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)  cnt_q <= '0;
      else if (waiting && !hs) cnt_q <= cnt_q + TIMEOUT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized transaction-level checking of multicycle_ctrl
// against a queue of expected per-cycle states and outputs.
`default_nettype none

module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [11:0] IAV  = 12'h800;
  localparam logic [11:0] DAV  = 12'h400;
  localparam logic [11:0] DW   = 12'h200;
  localparam logic [11:0] IFE  = 12'h100;
  localparam logic [11:0] RS1  = 12'h080;
  localparam logic [11:0] RS2  = 12'h040;
  localparam logic [11:0] RD   = 12'h020;
  localparam logic [11:0] SEL2 = 12'h010;
  localparam logic [11:0] SEL1 = 12'h008;
  localparam logic [11:0] PC   = 12'h004;
  localparam logic [11:0] PNS  = 12'h002;
  localparam logic [11:0] ERR  = 12'h001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ibus_addr_ready = 1'b0, ibus_data_valid = 1'b0;
  logic       dbus_addr_ready = 1'b0, dbus_data_valid = 1'b0;
  logic [5:0] inst_type = 6'd0;
  logic       rd_valid = 1'b0, branch_taken = 1'b0;
  logic       ibus_addr_valid, dbus_addr_valid, dbus_write, inst_fetch;
  logic       rs1_en, rs2_en, rd_en, pc_en, pc_next_sel, error;
  logic [1:0] rd_din_sel;
  logic [2:0] state;
  logic [11:0] act;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       iar, idv, dar, ddv;
    logic [5:0] it;
    logic       rv, bt;
    logic [2:0] st;
    logic [11:0] outs;
  } cyc_t;

  cyc_t q[$];

  multicycle_ctrl #(.RD_DIN_SEL_WIDTH(2), .TIMEOUT_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ibus_addr_ready(ibus_addr_ready), .ibus_data_valid(ibus_data_valid),
    .dbus_addr_ready(dbus_addr_ready), .dbus_data_valid(dbus_data_valid),
    .inst_type(inst_type), .rd_valid(rd_valid), .branch_taken(branch_taken),
    .ibus_addr_valid(ibus_addr_valid), .dbus_addr_valid(dbus_addr_valid),
    .dbus_write(dbus_write), .inst_fetch(inst_fetch),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_en(rd_en), .rd_din_sel(rd_din_sel),
    .pc_en(pc_en), .pc_next_sel(pc_next_sel), .error(error), .state(state)
  );

  assign act = {ibus_addr_valid, dbus_addr_valid, dbus_write, inst_fetch,
                rs1_en, rs2_en, rd_en, rd_din_sel, pc_en, pc_next_sel, error};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Unsampled inputs get random values, so they must never influence the outputs.
  function automatic cyc_t noise();
    cyc_t c;
    c.iar = 1'($urandom); c.idv = 1'($urandom);
    c.dar = 1'($urandom); c.ddv = 1'($urandom);
    c.it  = 6'($urandom); c.rv  = 1'($urandom); c.bt = 1'($urandom);
    c.st  = 3'd0; c.outs = 12'd0;
    return c;
  endfunction

  task automatic push_error();
    cyc_t c;
    for (int k = 0; k < 3; k++) begin
      c = noise(); c.st = 3'd7; c.outs = ERR;
      q.push_back(c);
    end
  endtask

  // One bus phase lasting d waiting cycles before the handshake; d >= TO never handshakes.
  task automatic push_wait(input logic [2:0] st, input int d, input int which,
                           input logic [5:0] it, input logic rv,
                           input logic [11:0] base, input logic [11:0] hs_outs,
                           output bit stuck);
    cyc_t c;
    int   n;
    n     = (d < TO) ? d + 1 : TO;
    stuck = (d >= TO);
    for (int k = 0; k < n; k++) begin
      c = noise();
      if (st >= 3'd5) begin c.it = it; c.rv = rv; end
      case (which)
        0:       c.iar = (k == d);
        1:       c.idv = (k == d);
        2:       c.dar = (k == d);
        default: c.ddv = (k == d);
      endcase
      c.st   = st;
      c.outs = base | ((k == d) ? hs_outs : 12'd0);
      q.push_back(c);
    end
    if (stuck) push_error();
  endtask

  // kind 0..5 = one-hot type index, 6 = illegal code 'bad'.
  task automatic push_insn(input int kind, input logic [5:0] bad, input logic rv, input logic bt,
                           input int d0, input int d1, input int d2, input int d3,
                           output bit stuck);
    cyc_t       c;
    logic [5:0] it;
    bit         legal, ld, sv;
    legal = (kind < 6);
    it    = legal ? 6'(1 << kind) : bad;
    ld    = (kind == 3);
    sv    = (kind == 4);
    push_wait(3'd1, d0, 0, it, rv, IAV, 12'd0, stuck);
    if (stuck) return;
    push_wait(3'd2, d1, 1, it, rv, 12'd0, IFE, stuck);
    if (stuck) return;
    c = noise(); c.it = it; c.rv = rv; c.st = 3'd3;
    c.outs = legal ? (RS1 | ((kind == 2 || kind == 4 || kind == 5) ? RS2 : 12'd0)) : 12'd0;
    q.push_back(c);
    if (!legal) begin push_error(); stuck = 1'b1; return; end
    c = noise(); c.it = it; c.rv = rv; c.bt = bt; c.st = 3'd4;
    case (kind)
      0:       c.outs = (rv ? RD : 12'd0) | PC;
      1, 2:    c.outs = (rv ? RD : 12'd0) | SEL1 | PC;
      5:       c.outs = PC | (bt ? PNS : 12'd0);
      default: c.outs = 12'd0;
    endcase
    q.push_back(c);
    if (ld || sv) begin
      push_wait(3'd5, d2, 2, it, rv, DAV | (sv ? DW : 12'd0), 12'd0, stuck);
      if (stuck) return;
      push_wait(3'd6, d3, 3, it, rv, 12'd0,
                PC | ((ld && rv) ? RD : 12'd0) | (ld ? SEL2 : 12'd0), stuck);
    end
  endtask

  task automatic run_queue(input int n);
    cyc_t c;
    int   done = 0;
    while (q.size() > 0 && (n < 0 || done < n)) begin
      c = q.pop_front();
      @(negedge clk);
      ibus_addr_ready = c.iar; ibus_data_valid = c.idv;
      dbus_addr_ready = c.dar; dbus_data_valid = c.ddv;
      inst_type = c.it; rd_valid = c.rv; branch_taken = c.bt;
      #1;
      checks++;
      if (state !== c.st) begin
        errors++;
        $display("FAIL state @%0t: got %0d expected %0d", $time, state, c.st);
      end
      checks++;
      if (act !== c.outs) begin
        errors++;
        $display("FAIL outputs @%0t (state %0d): got %b expected %b", $time, c.st, act, c.outs);
      end
      done++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || act !== 12'd0) begin
      errors++;
      $display("FAIL async_reset: got state %0d outs %b expected 0 / 0", state, act);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (state !== 3'd0 || act !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: got state %0d outs %b expected 0 / 0", state, act);
    end
    do_reset();
  endtask

  task automatic test_zero_wait();
    bit s;
    push_insn(1, 6'd0, 1'b1, 1'b0, 0, 0, 0, 0, s);
    push_insn(1, 6'd0, 1'b1, 1'b0, 0, 0, 0, 0, s);
    push_insn(3, 6'd0, 1'b1, 1'b0, 0, 0, 0, 0, s);
    push_insn(4, 6'd0, 1'b1, 1'b0, 0, 0, 0, 0, s);
    push_insn(5, 6'd0, 1'b0, 1'b1, 0, 0, 0, 0, s);
    push_insn(5, 6'd0, 1'b0, 1'b0, 0, 0, 0, 0, s);
    push_insn(0, 6'd0, 1'b1, 1'b0, 0, 0, 0, 0, s);
    push_insn(2, 6'd0, 1'b0, 1'b0, 0, 0, 0, 0, s);
    run_queue(-1);
  endtask

  task automatic test_random();
    bit         s;
    int         r, kind;
    int         d[4];
    logic [5:0] bad;
    for (int i = 0; i < 60; i++) begin
      r    = int'($urandom_range(0, 19));
      kind = (r < 18) ? (r % 6) : 6;
      do bad = 6'($urandom); while ($countones(bad) == 1);
      for (int j = 0; j < 4; j++)
        d[j] = ($urandom_range(0, 24) == 0) ? TO : int'($urandom_range(0, TO - 1));
      push_insn(kind, bad, 1'($urandom), 1'($urandom), d[0], d[1], d[2], d[3], s);
      run_queue(-1);
      if (s) do_reset();
    end
  endtask

  task automatic test_timeout();
    bit s;
    push_insn(1, 6'd0, 1'b1, 1'b0, TO, 0, 0, 0, s);
    run_queue(-1);
    do_reset();
    push_insn(3, 6'd0, 1'b1, 1'b0, 0, 0, 0, TO - 1, s);
    push_insn(6, 6'b000011, 1'b1, 1'b0, 0, 0, 0, 0, s);
    run_queue(-1);
    do_reset();
    push_insn(6, 6'b000000, 1'b1, 1'b0, 1, 2, 0, 0, s);
    run_queue(-1);
    do_reset();
    push_insn(4, 6'd0, 1'b1, 1'b0, 0, 0, TO, 0, s);
    run_queue(-1);
    do_reset();
    push_insn(3, 6'd0, 1'b1, 1'b0, 0, TO - 1, 0, TO, s);
    run_queue(-1);
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit s;
    push_insn(3, 6'd0, 1'b1, 1'b0, 0, 0, 0, 2, s);
    run_queue(6);
    q.delete();
    #1 dbus_data_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || act !== 12'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got state %0d outs %b expected 0 / 0", state, act);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || act !== 12'd0) begin
      errors++;
      $display("FAIL mid_reset_hold: got state %0d outs %b expected 0 / 0", state, act);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (state !== 3'd1 || act !== IAV) begin
      errors++;
      $display("FAIL mid_reset_release: got state %0d outs %b expected 1 / %b", state, act, IAV);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RD_DIN_SEL_WIDTH, 2, width of rd_din_sel.
- TIMEOUT_WIDTH, 8, width of the bus-wait counter.
- TIMEOUT_CYCLES, 16, maximum wait cycles per bus phase; 0 disables the timeout.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ibus_addr_ready  in  1  instruction bus accepts the request.
- ibus_data_valid  in  1  instruction word returned.
- dbus_addr_ready  in  1  data bus accepts the request.
- dbus_data_valid  in  1  load data or store acknowledge returned.
- inst_type  in  6  one-hot: [0] IMM, [1] INT_IMM, [2] INT_REG, [3] LOAD, [4] STORE, [5] BRANCH.
- rd_valid  in  1  destination register is not x0.
- branch_taken  in  1  branch condition true.
- ibus_addr_valid  out  1  instruction fetch request.
- dbus_addr_valid  out  1  data request.
- dbus_write  out  1  data request is a store.
- inst_fetch  out  1  latch the instruction word.
- rs1_en, rs2_en  out  1 each  register-file read enables.
- rd_en  out  1  register-file write enable.
- rd_din_sel  out  RD_DIN_SEL_WIDTH  write source: 0 IMM, 1 ALU, 2 MEM.
- pc_en  out  1  update PC.
- pc_next_sel  out  1  0 selects PC+4, 1 selects branch target.
- error  out  1  sticky bus-timeout or illegal-instruction flag.
- state  out  3  current state, for debug.

Function
REQ-003 The state encoding SHALL be RESET=0, FETCH=1, FETCH_WAIT=2, DECODE=3, EXEC=4, MEM=5, MEM_WAIT=6, ERROR=7; state and the wait counter are the only registers.
REQ-004 All outputs SHALL be combinational functions of state, inputs and parameters; any output not named for a state is 0.
REQ-005 RESET SHALL go to FETCH unconditionally on the next clock.
REQ-006 FETCH SHALL drive ibus_addr_valid=1 and go to FETCH_WAIT in the cycle where ibus_addr_ready=1.
REQ-007 FETCH_WAIT SHALL drive inst_fetch=ibus_data_valid and go to DECODE in the cycle where ibus_data_valid=1.
REQ-008 DECODE SHALL drive rs1_en=1 for every legal type and rs2_en=1 for INT_REG, STORE and BRANCH.
- Next state is EXEC when inst_type is legal.
- Next state is ERROR when inst_type is not exactly one-hot (zero bits set or more than one set).
REQ-009 EXEC behaviour by type:
- IMM or INT_IMM or INT_REG: rd_en=rd_valid; rd_din_sel=0 for IMM, 1 otherwise; pc_en=1, pc_next_sel=0; go to FETCH.
- BRANCH: pc_en=1, pc_next_sel=branch_taken; go to FETCH.
- LOAD or STORE: go to MEM.
REQ-010 MEM SHALL drive dbus_addr_valid=1 and dbus_write=inst_type[4], and go to MEM_WAIT in the cycle where dbus_addr_ready=1.
REQ-011 In MEM_WAIT, in the cycle where dbus_data_valid=1:
- LOAD drives rd_en=rd_valid and rd_din_sel=2.
- Both LOAD and STORE drive pc_en=1 and pc_next_sel=0, then go to FETCH.
REQ-012 Wait counter, TIMEOUT_WIDTH bits:
- Clears on every state change.
- Increments each cycle in FETCH, FETCH_WAIT, MEM or MEM_WAIT whose completing handshake is absent.
- When TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 with the handshake still absent, the next state is ERROR.
- A handshake in that same cycle wins over the timeout.
REQ-013 ERROR SHALL drive error=1 and hold all other outputs at 0; it is exited only by rst.
REQ-014 A wide TIMEOUT_WIDTH SHALL never wrap the counter before TIMEOUT_CYCLES-1 is reached; elaboration SHALL fail if TIMEOUT_CYCLES >= 2**TIMEOUT_WIDTH.
REQ-015 Input changes in states that do not sample them SHALL have no effect.

Reset
REQ-016 rst=1 SHALL immediately force state=RESET and counter=0, with no clock needed; all outputs are then 0, including error.
REQ-017 Asserting rst mid-transaction (any state) SHALL abandon the transaction with no further pc_en or rd_en; after release, FETCH is entered one cycle later.

Verification
REQ-018 Zero-wait bus (all ready/valid=1), INT_IMM, rd_valid=1: states 1,2,3,4,1; rd_en=1 and rd_din_sel=1 in EXEC only; 4 cycles per instruction.
REQ-019 Zero-wait bus, LOAD: states 1,2,3,4,5,6,1; rd_din_sel=2 and rd_en=1 only in MEM_WAIT; STORE gives the same sequence with dbus_write=1 in MEM and rd_en=0 throughout.
REQ-020 BRANCH with branch_taken=1, then branch_taken=0: pc_en=1 in EXEC, with pc_next_sel 1 then 0; rs2_en=1 in DECODE.
REQ-021 TIMEOUT_CYCLES=4, ibus_addr_ready=0: 4 cycles in FETCH, then state=7 and error=1; remains stuck with ready=1 until rst, after which error=0.
REQ-022 TIMEOUT_CYCLES=4, dbus_data_valid asserted on the 4th MEM_WAIT cycle: no error, FETCH next; inst_type=6'b000011 in DECODE gives ERROR.
REQ-023 rst pulsed mid-MEM_WAIT between clock edges: state=0 asynchronously, no rd_en pulse; FETCH one cycle after release.
